uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Serial output stage downstream of the CPU core; it drives the top-level tx pin. The CPU writes bytes through a store-strobe/data pair into a small FIFO. An 8N1 transmitter state machine drains the FIFO, LSB first, at a fixed bit period. Status flags are exported so the CPU can poll for space and completion.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2)
FIFO_DEPTH, 4, FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  store strobe, one byte per asserted cycle
wr_data  input  8  byte to enqueue, sampled when wr_en=1
ovf_clr  input  1  clears sticky overflow flag
tx  output  1  serial line, idle high
busy  output  1  1 while FSM is not IDLE or FIFO non-empty
full  output  1  FIFO holds FIFO_DEPTH bytes
empty  output  1  FIFO holds 0 bytes
overflow  output  1  sticky: a write was dropped
status  output  8  {4'b0, overflow, busy, full, empty}, for CPU read

Behaviour:
- Reset (rst_n=0, async): tx=1, FIFO count=0 (empty=1, full=0), busy=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame immediately: tx returns high, queued bytes are lost.
- All outputs are registered or decoded from registered state only. No combinational path from wr_en to tx.
- FIFO: circular buffer with read/write pointers. Width is log2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Write accept: wr_en=1 and (full=0, or a pop occurs in the same cycle). An accepted byte is stored at wr_ptr and wr_ptr increments.
- Write drop: wr_en=1, full=1 and no pop that cycle. FIFO is unchanged and overflow is set at the next edge.
- Overflow clear: ovf_clr=1 clears overflow. If a clear and a drop occur in the same cycle, the set wins.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop the head byte into an 8-bit shift register, clear the baud counter, and go to START. The pop happens on the same edge as the transition.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0]. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if empty=0, pop and go directly to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. A bit ends on the cycle the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- tx is registered. It reflects state on the same edge as the state transition.
- Latency: a byte written at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1, and tx falls at edge k+1. The frame is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- busy = (FSM != IDLE) | ~empty. It deasserts on the edge where STOP exits to IDLE with the FIFO empty.
- Capacity: during transmission, FIFO_DEPTH further bytes may be queued. The byte in the shift register does not occupy a FIFO slot.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Required: tx=1, status=8'h01, stays stable for 100 cycles with no writes.
- Single byte, CLKS_PER_BIT=4: write 8'hA5 at edge k. Required: tx=0 over cycles k+1..k+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. busy falls at k+41.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles. Required: second start bit begins the cycle right after the first stop bit ends. Total tx activity is 80 cycles, with no idle gap between frames.
- Full/overflow, FIFO_DEPTH=4: write 6 bytes on consecutive cycles. First is popped at once, next 4 are queued, giving full=1. Required: sixth write is dropped, overflow=1, status=8'h0E. Then pulse ovf_clr: overflow=0 and the other flags are unchanged.
- Push on pop: with FIFO full, write on the exact cycle STOP pops. Required: write is accepted, overflow stays 0, full stays 1.
- Reset mid-frame: assert rst_n=0 during DATA bit 3. Required: tx=1 immediately (async), all flags at reset values. After release, no residual frame is transmitted.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-facing byte FIFO feeding an 8N1 serial transmitter.
// Bytes go out LSB first at CLKS_PER_BIT clocks per bit. Frames run
// back-to-back with no idle gap while the FIFO has data.
// tx and all status flags come from registered state only.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic [7:0] status
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_MAX   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Transmitter state
  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        shift_nxt;
  logic              tx_q;
  logic              tx_nxt;

  logic bit_end;
  logic pop;
  logic push;
  logic drop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign busy     = (state != IDLE) || !empty;
  assign tx       = tx_q;
  assign status   = {4'b0000, overflow, busy, full, empty};

  assign bit_end  = (baud_cnt == BAUD_MAX);

  // A pop loads the shifter. It happens when leaving IDLE, or at the end of
  // a stop bit when more data is waiting.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  // A full FIFO still accepts a byte if the same edge frees a slot.
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  // Next-state logic for the transmitter FSM.
  always_comb begin
    // NOTE: default assignment first so that no path leaves state_nxt unassigned (prevents a latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the next shifter contents and the tx level for the next state.
  always_comb begin
    shift_nxt = shift;
    if (pop) begin
      shift_nxt = mem[rd_ptr];
    end else if ((state == DATA) && bit_end) begin
      shift_nxt = {1'b0, shift[7:1]};
    end

    tx_nxt = 1'b1;
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // State register plus the baud, bit, shift and tx registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
      state <= state_nxt;
      shift <= shift_nxt;
      tx_q  <= tx_nxt;

      if (pop) begin
        baud_cnt <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      if (state == START) begin
        bit_idx <= 3'd0;
      end else if ((state == DATA) && bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
